// File: rtl/local_controller_prefetch_node.sv
// One node of a four-node circular delay line: gapless write pass, token-chained stream reads
// and a lower-priority backward prefetch, both emitted as routed packets.
module local_controller_prefetch_node #(
    parameter int N_sample             = 256,
    parameter int datawidth            = 16,
    parameter int address_vector_width = 4,
    parameter int sample_address_width = 8,
    parameter int packet_width         = 2 + 2*datawidth + address_vector_width
) (
    input  logic                              CLK,
    input  logic                              reset,
    input  logic                              boot_up,
    input  logic                              start,
    input  logic [2*datawidth-1:0]            D,
    input  logic                              write_flag,
    input  logic                              input_write_boundary,
    output logic                              write_boundary_next,
    input  logic                              input_boundary_flag,
    input  logic [address_vector_width-1:0]   prev_dest_address,
    output logic                              boundary_next,
    output logic [address_vector_width-1:0]   dest_address,
    output logic [packet_width-1:0]           packet_out,
    input  logic                              from_glob_prefetch_valid,
    input  logic [sample_address_width-1:0]   from_glob_prefetch_start,
    input  logic [sample_address_width-1:0]   from_glob_prefetch_stop,
    input  logic [address_vector_width-1:0]   from_glob_prefetch_dest,
    input  logic                              input_prefetch_boundary_flag,
    input  logic [sample_address_width-1:0]   prefetch_next_stop_address,
    input  logic [address_vector_width-1:0]   prefetch_next_dest_addr,
    output logic                              prefetch_boundary_prev,
    output logic [sample_address_width-1:0]   prefetch_stop_address,
    output logic [address_vector_width-1:0]   prefetch_dest_addr,
    input  logic                              scenario_update
);
    localparam int SW = 2*datawidth;
    localparam logic [sample_address_width-1:0] LAST_ADDR = sample_address_width'(N_sample - 1);
    localparam logic [sample_address_width-1:0] ONE       = sample_address_width'(1);
    localparam logic [sample_address_width-1:0] ZERO      = '0;

    logic [SW-1:0] mem [N_sample];

    logic                            wr_active_q, wr_active_d;
    logic [sample_address_width-1:0] wr_addr_q, wr_addr_d;
    logic [sample_address_width-1:0] rd_addr_q, rd_addr_d;
    logic [address_vector_width-1:0] rd_dest_q, rd_dest_d;
    logic                            armed_q, armed_d;
    logic                            streaming_q, streaming_d;
    logic [sample_address_width-1:0] pf_addr_q, pf_addr_d;
    logic [sample_address_width-1:0] pf_stop_q, pf_stop_d;
    logic [address_vector_width-1:0] pf_dest_q, pf_dest_d;
    logic                            pf_active_q, pf_active_d;
    logic                            pf_cfg_valid_q, pf_cfg_valid_d;
    logic                            pkt_valid_q, pkt_valid_d;
    logic                            pkt_pf_q, pkt_pf_d;
    logic [address_vector_width-1:0] pkt_dest_q, pkt_dest_d;
    logic [SW-1:0]                   rd_data_q;

    logic                            stream_rd;
    logic                            pf_rd;
    logic                            pf_load;
    logic                            rd_en;
    logic [sample_address_width-1:0] rd_mux;

    always_comb begin
        wr_active_d    = wr_active_q;
        wr_addr_d      = wr_addr_q;
        rd_addr_d      = rd_addr_q;
        rd_dest_d      = rd_dest_q;
        armed_d        = armed_q;
        streaming_d    = streaming_q;
        pf_addr_d      = pf_addr_q;
        pf_stop_d      = pf_stop_q;
        pf_dest_d      = pf_dest_q;
        pf_active_d    = pf_active_q;
        pf_cfg_valid_d = pf_cfg_valid_q;

        stream_rd = streaming_q;
        pf_rd     = pf_active_q && !streaming_q;
        pf_load   = from_glob_prefetch_valid && !boot_up;
        rd_en     = stream_rd || pf_rd;
        rd_mux    = stream_rd ? rd_addr_q : pf_addr_q;

        write_boundary_next    = wr_active_q && (wr_addr_q == LAST_ADDR);
        boundary_next          = streaming_q && (rd_addr_q == LAST_ADDR);
        prefetch_boundary_prev = pf_rd && (pf_addr_q != pf_stop_q) && (pf_addr_q == ZERO);

        if (wr_active_q) begin
            wr_addr_d = wr_addr_q + ONE;
            if (wr_addr_q == LAST_ADDR)
                wr_active_d = 1'b0;
        end
        if (write_flag || input_write_boundary) begin
            wr_addr_d   = ZERO;
            wr_active_d = 1'b1;
        end

        if (streaming_q) begin
            rd_addr_d = rd_addr_q + ONE;
            if (rd_addr_q == LAST_ADDR)
                streaming_d = 1'b0;
        end
        if (from_glob_prefetch_valid && boot_up) begin
            rd_addr_d = from_glob_prefetch_start;
            rd_dest_d = from_glob_prefetch_dest;
            armed_d   = 1'b1;
        end
        if (start && armed_q) begin
            streaming_d = 1'b1;
            armed_d     = 1'b0;
        end

        // A prefetch that loses the port to a stream read keeps its address for the next cycle.
        if (pf_rd) begin
            if (pf_addr_q == pf_stop_q || pf_addr_q == ZERO)
                pf_active_d = 1'b0;
            else
                pf_addr_d = pf_addr_q - ONE;
        end

        if (scenario_update && !pf_load) begin
            pf_active_d = 1'b0;
            if (pf_cfg_valid_q) begin
                rd_dest_d      = pf_dest_q;
                pf_cfg_valid_d = 1'b0;
            end
        end

        if (input_boundary_flag) begin
            rd_addr_d   = ZERO;
            rd_dest_d   = prev_dest_address;
            streaming_d = 1'b1;
        end

        if (input_prefetch_boundary_flag) begin
            pf_addr_d   = LAST_ADDR;
            pf_stop_d   = prefetch_next_stop_address;
            pf_dest_d   = prefetch_next_dest_addr;
            pf_active_d = 1'b1;
        end
        if (pf_load) begin
            pf_addr_d      = from_glob_prefetch_start;
            pf_stop_d      = from_glob_prefetch_stop;
            pf_dest_d      = from_glob_prefetch_dest;
            pf_active_d    = 1'b1;
            pf_cfg_valid_d = 1'b1;
        end

        pkt_valid_d = rd_en;
        pkt_pf_d    = pf_rd;
        pkt_dest_d  = '0;
        if (stream_rd)
            pkt_dest_d = rd_dest_q;
        else if (pf_rd)
            pkt_dest_d = pf_dest_q;
    end

    // Sample store: not reset; read returns pre-write data on an address collision.
    always_ff @(posedge CLK) begin
        if (wr_active_q)
            mem[wr_addr_q] <= D;
        if (rd_en)
            rd_data_q <= mem[rd_mux];
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_active_q    <= 1'b0;
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            rd_dest_q      <= '0;
            armed_q        <= 1'b0;
            streaming_q    <= 1'b0;
            pf_addr_q      <= '0;
            pf_stop_q      <= '0;
            pf_dest_q      <= '0;
            pf_active_q    <= 1'b0;
            pf_cfg_valid_q <= 1'b0;
            pkt_valid_q    <= 1'b0;
            pkt_pf_q       <= 1'b0;
            pkt_dest_q     <= '0;
        end else begin
            wr_active_q    <= wr_active_d;
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            rd_dest_q      <= rd_dest_d;
            armed_q        <= armed_d;
            streaming_q    <= streaming_d;
            pf_addr_q      <= pf_addr_d;
            pf_stop_q      <= pf_stop_d;
            pf_dest_q      <= pf_dest_d;
            pf_active_q    <= pf_active_d;
            pf_cfg_valid_q <= pf_cfg_valid_d;
            pkt_valid_q    <= pkt_valid_d;
            pkt_pf_q       <= pkt_pf_d;
            pkt_dest_q     <= pkt_dest_d;
        end
    end

    // RAM data register has no reset, so the packet is forced to zero when not valid.
    assign packet_out            = pkt_valid_q ? {pkt_valid_q, pkt_pf_q, rd_data_q, pkt_dest_q} : '0;
    assign dest_address          = rd_dest_q;
    assign prefetch_stop_address = pf_stop_q;
    assign prefetch_dest_addr    = pf_dest_q;

endmodule

// File: tb/tb_local_controller_prefetch_node.sv
// Randomized scoreboard bench: stimulus pushes expected packets into stream/prefetch queues,
// a monitor pops and compares whenever a valid packet appears.
module tb_local_controller_prefetch_node;
    localparam int DW  = 16;
    localparam int AVW = 4;
    localparam int SAW = 8;
    localparam int PW  = 2 + 2*DW + AVW;

    logic           CLK = 1'b0;
    logic           reset = 1'b1;
    logic           boot_up = 1'b0;
    logic           start = 1'b0;
    logic [2*DW-1:0] D = '0;
    logic           write_flag = 1'b0;
    logic           input_write_boundary = 1'b0;
    logic           write_boundary_next;
    logic           input_boundary_flag = 1'b0;
    logic [AVW-1:0] prev_dest_address = '0;
    logic           boundary_next;
    logic [AVW-1:0] dest_address;
    logic [PW-1:0]  packet_out;
    logic           from_glob_prefetch_valid = 1'b0;
    logic [SAW-1:0] from_glob_prefetch_start = '0;
    logic [SAW-1:0] from_glob_prefetch_stop = '0;
    logic [AVW-1:0] from_glob_prefetch_dest = '0;
    logic           input_prefetch_boundary_flag = 1'b0;
    logic [SAW-1:0] prefetch_next_stop_address = '0;
    logic [AVW-1:0] prefetch_next_dest_addr = '0;
    logic           prefetch_boundary_prev;
    logic [SAW-1:0] prefetch_stop_address;
    logic [AVW-1:0] prefetch_dest_addr;
    logic           scenario_update = 1'b0;

    local_controller_prefetch_node dut (
        .CLK(CLK), .reset(reset), .boot_up(boot_up), .start(start), .D(D),
        .write_flag(write_flag), .input_write_boundary(input_write_boundary),
        .write_boundary_next(write_boundary_next),
        .input_boundary_flag(input_boundary_flag), .prev_dest_address(prev_dest_address),
        .boundary_next(boundary_next), .dest_address(dest_address), .packet_out(packet_out),
        .from_glob_prefetch_valid(from_glob_prefetch_valid),
        .from_glob_prefetch_start(from_glob_prefetch_start),
        .from_glob_prefetch_stop(from_glob_prefetch_stop),
        .from_glob_prefetch_dest(from_glob_prefetch_dest),
        .input_prefetch_boundary_flag(input_prefetch_boundary_flag),
        .prefetch_next_stop_address(prefetch_next_stop_address),
        .prefetch_next_dest_addr(prefetch_next_dest_addr),
        .prefetch_boundary_prev(prefetch_boundary_prev),
        .prefetch_stop_address(prefetch_stop_address),
        .prefetch_dest_addr(prefetch_dest_addr),
        .scenario_update(scenario_update)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pkt_seen = 0;
    int run_cnt = 0;
    int run_first = 0;
    int run_last = 0;

    logic [2*DW-1:0] mem_model [256];
    logic [PW-1:0]   sq[$];
    logic [PW-1:0]   pq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Monitor: one sample per cycle, just after the active edge.
    initial begin
        logic [PW-1:0] exp;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (packet_out[PW-1]) begin
                pkt_seen++;
                $display("[TB] pkt pf=%0d data=%h dest=%h", packet_out[PW-2], packet_out[PW-3:AVW], packet_out[AVW-1:0]);
                if (packet_out[PW-2]) begin
                    if (pq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_pf_pkt: got %0h required none", packet_out);
                    end else begin
                        exp = pq.pop_front();
                        check("pf_pkt", 64'(packet_out), 64'(exp));
                    end
                end else begin
                    if (run_cnt == 0) run_first = cyc;
                    run_last = cyc;
                    run_cnt++;
                    if (sq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_stream_pkt: got %0h required none", packet_out);
                    end else begin
                        exp = sq.pop_front();
                        check("stream_pkt", 64'(packet_out), 64'(exp));
                    end
                end
            end else begin
                check("idle_pkt_zero", 64'(packet_out), 64'd0);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

    task automatic push_stream(input int s, input logic [AVW-1:0] d);
        for (int a = s; a < 256; a++) sq.push_back({1'b1, 1'b0, mem_model[a], d});
    endtask

    // Backward walk from s, stopping at t (inclusive) or at address 0.
    task automatic push_pf(input int s, input int t, input logic [AVW-1:0] d);
        int a = s;
        forever begin
            pq.push_back({1'b1, 1'b1, mem_model[a], d});
            if (a == t || a == 0) break;
            a--;
        end
    endtask

    task automatic write_pass(input bit use_token);
        logic [2*DW-1:0] w;
        @(negedge CLK);
        if (use_token) input_write_boundary = 1'b1; else write_flag = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            write_flag = 1'b0; input_write_boundary = 1'b0;
            w = $urandom; D = w; mem_model[i] = w;
            #1;
            check("write_boundary_next", 64'(write_boundary_next), 64'(i == 255));
        end
        @(negedge CLK);
        D = $urandom;
        #1 check("write_boundary_after", 64'(write_boundary_next), 64'd0);
        for (int i = 0; i < 4; i++) begin @(negedge CLK); D = $urandom; end
        $display("[TB] write pass done token=%0d", use_token);
    endtask

    // Caller drives the launching pulse at the current negedge; cycle 1 reads the first address.
    task automatic wait_boundary(input int exp_n);
        int n = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge CLK);
            start = 1'b0; input_boundary_flag = 1'b0;
            #1;
            if (boundary_next) begin n = k; break; end
        end
        check("boundary_next_cycle", 64'(n), 64'(exp_n));
        @(negedge CLK);
        #1 check("boundary_next_single", 64'(boundary_next), 64'd0);
    endtask

    task automatic check_run(input int exp_cnt);
        for (int i = 0; i < 3; i++) @(negedge CLK);
        check("stream_count", 64'(run_cnt), 64'(exp_cnt));
        check("stream_contiguous", 64'(run_last - run_first), 64'(exp_cnt - 1));
        check("stream_queue_empty", 64'(sq.size()), 64'd0);
        run_cnt = 0;
    endtask

    task automatic run_pf(input int s, input int t, input logic [AVW-1:0] d);
        bit tok = 0;
        @(negedge CLK);
        from_glob_prefetch_valid = 1'b1; boot_up = 1'b0;
        from_glob_prefetch_start = SAW'(s); from_glob_prefetch_stop = SAW'(t); from_glob_prefetch_dest = d;
        push_pf(s, t, d);
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            from_glob_prefetch_valid = 1'b0;
            #1;
            if (prefetch_boundary_prev) tok = 1;
            if (pq.size() == 0) break;
        end
        for (int i = 0; i < 3; i++) @(negedge CLK);
        check("pf_run_drained", 64'(pq.size()), 64'd0);
        check("pf_token", 64'(tok), 64'(s < t));
        check("pf_stop_out", 64'(prefetch_stop_address), 64'(t));
        $display("[TB] prefetch run start=%h stop=%h dest=%h", s, t, d);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_packet"}, 64'(packet_out), 64'd0);
        check({tag, "_dest"}, 64'(dest_address), 64'd0);
        check({tag, "_bnd"}, 64'({boundary_next, write_boundary_next, prefetch_boundary_prev}), 64'd0);
        check({tag, "_pfout"}, 64'({prefetch_stop_address, prefetch_dest_addr}), 64'd0);
    endtask

    initial begin
        int seen;
        bit tok;
        logic [AVW-1:0] rd;

        #2;
        check_outputs_zero("reset");
        repeat (2) @(negedge CLK);
        reset = 1'b0;

        write_pass(1'b0);
        write_pass(1'b1);

        // Boot-time stream configuration, then start.
        @(negedge CLK);
        boot_up = 1'b1; from_glob_prefetch_valid = 1'b1;
        from_glob_prefetch_start = 8'h19; from_glob_prefetch_dest = 4'b1000;
        @(negedge CLK);
        boot_up = 1'b0; from_glob_prefetch_valid = 1'b0;
        #1 check("stream_dest_cfg", 64'(dest_address), 64'h8);
        push_stream(8'h19, 4'b1000);
        run_cnt = 0;
        @(negedge CLK);
        start = 1'b1;
        wait_boundary(256 - 8'h19);
        check_run(256 - 8'h19);
        $display("[TB] boot stream done");

        // Start with nothing armed must not stream.
        seen = pkt_seen;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        repeat (10) @(negedge CLK);
        check("start_unarmed", 64'(pkt_seen), 64'(seen));

        // Prefetch running, then a stream token arrives and takes the port.
        @(negedge CLK);
        from_glob_prefetch_valid = 1'b1;
        from_glob_prefetch_start = 8'h30; from_glob_prefetch_stop = 8'hE0; from_glob_prefetch_dest = 4'b0110;
        push_pf(8'h30, 8'hE0, 4'b0110);
        @(negedge CLK); from_glob_prefetch_valid = 1'b0;
        repeat (3) @(negedge CLK);
        rd = 4'($urandom_range(1, 15));
        input_boundary_flag = 1'b1; prev_dest_address = rd;
        push_stream(0, rd);
        run_cnt = 0;
        wait_boundary(256);
        check("token_stream_dest", 64'(dest_address), 64'(rd));
        tok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK); #1;
            if (prefetch_boundary_prev) begin tok = 1; break; end
        end
        check("overlap_pf_token", 64'(tok), 64'd1);
        check_run(256);
        check("overlap_pf_drained", 64'(pq.size()), 64'd0);
        check("pf_stop_addr_out", 64'(prefetch_stop_address), 64'hE0);
        check("pf_dest_out", 64'(prefetch_dest_addr), 64'h6);
        $display("[TB] overlap stream/prefetch done");

        // Acting as previous node: prefetch token from the next node.
        @(negedge CLK);
        input_prefetch_boundary_flag = 1'b1;
        prefetch_next_stop_address = 8'hE0; prefetch_next_dest_addr = 4'b0110;
        push_pf(8'hFF, 8'hE0, 4'b0110);
        tok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            input_prefetch_boundary_flag = 1'b0;
            #1;
            if (prefetch_boundary_prev) tok = 1;
        end
        check("prev_node_no_token", 64'(tok), 64'd0);
        check("prev_node_drained", 64'(pq.size()), 64'd0);

        for (int r = 0; r < 3; r++)
            run_pf($urandom_range(0, 255), $urandom_range(0, 255), 4'($urandom_range(0, 15)));

        // scenario_update three cycles after a load: exactly three packets escape.
        @(negedge CLK);
        from_glob_prefetch_valid = 1'b1;
        from_glob_prefetch_start = 8'h80; from_glob_prefetch_stop = 8'h10; from_glob_prefetch_dest = 4'b0110;
        push_pf(8'h80, 8'h7E, 4'b0110);
        @(negedge CLK); from_glob_prefetch_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK); scenario_update = 1'b1;
        @(negedge CLK); scenario_update = 1'b0;
        #1 check("scenario_dest", 64'(dest_address), 64'h6);
        repeat (6) @(negedge CLK);
        check("scenario_pf_stopped", 64'(pq.size()), 64'd0);
        @(negedge CLK);
        input_prefetch_boundary_flag = 1'b1;
        prefetch_next_stop_address = 8'hFE; prefetch_next_dest_addr = 4'hA;
        push_pf(8'hFF, 8'hFE, 4'hA);
        @(negedge CLK); input_prefetch_boundary_flag = 1'b0;
        repeat (5) @(negedge CLK);
        scenario_update = 1'b1;
        @(negedge CLK); scenario_update = 1'b0;
        #1 check("scenario_second_dest", 64'(dest_address), 64'h6);
        check("scenario_second_pfdest", 64'(prefetch_dest_addr), 64'hA);
        check("scenario_second_drained", 64'(pq.size()), 64'd0);
        $display("[TB] scenario_update done");

        // Reset mid-stream.
        @(negedge CLK);
        boot_up = 1'b1; from_glob_prefetch_valid = 1'b1;
        from_glob_prefetch_start = 8'h00; from_glob_prefetch_dest = 4'b0010;
        @(negedge CLK);
        boot_up = 1'b0; from_glob_prefetch_valid = 1'b0;
        push_stream(0, 4'b0010);
        start = 1'b1;
        @(negedge CLK); start = 1'b0;
        repeat (10) @(negedge CLK);
        reset = 1'b1; sq.delete(); pq.delete();
        #1 check_outputs_zero("rst_stream");
        repeat (2) @(negedge CLK);
        reset = 1'b0;

        // Reset mid-prefetch.
        @(negedge CLK);
        from_glob_prefetch_valid = 1'b1;
        from_glob_prefetch_start = 8'h40; from_glob_prefetch_stop = 8'h00; from_glob_prefetch_dest = 4'b0101;
        push_pf(8'h40, 8'h00, 4'b0101);
        @(negedge CLK); from_glob_prefetch_valid = 1'b0;
        repeat (4) @(negedge CLK);
        reset = 1'b1; sq.delete(); pq.delete();
        #1 check_outputs_zero("rst_prefetch");
        repeat (2) @(negedge CLK);
        reset = 1'b0;

        seen = pkt_seen;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        repeat (20) @(negedge CLK);
        check("start_after_reset", 64'(pkt_seen), 64'(seen));
        check("final_queues_empty", 64'(sq.size() + pq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
